// File: rtl/neuron_accumulator_if.sv
// Handshake bundle between the multiplier, the neuron accumulator and the
// activation/writeback stage. The master side feeds products and consumes
// results; the slave side is the accumulator itself.
interface neuron_accumulator_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_product;
  logic [31:0] in_bias;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sat;
  logic [15:0] out_count;

  modport master (
    output in_valid, in_product, in_bias, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_sat, out_count
  );

  modport slave (
    input  in_valid, in_product, in_bias, in_last, out_ready,
    output in_ready, out_valid, out_data, out_sat, out_count
  );
endinterface

// File: rtl/neuron_accumulator.sv
// Streaming multiply-accumulate back end for one neuron.
// Adds a per-vector bias to a stream of signed Q16.16 products in a
// 32+ACC_GUARD bit accumulator and presents one saturated Q16.16 result per
// vector on a valid/ready output.
// Optional feature: define NEURON_ACC_RELU_EN to zero negative results
// (out_sat still reports 32-bit clamping).
module neuron_accumulator #(
  parameter int ACC_GUARD = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  neuron_accumulator_if.slave  bus
);

  localparam int DATA_W = 32;
  localparam int ACC_W  = DATA_W + ACC_GUARD;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic                     accept;
  logic                     rdy;
  logic signed [ACC_W-1:0]  acc_p0;
  logic signed [ACC_W-1:0]  acc_sum;
  logic [CNT_W-1:0]         cnt_p0;
  logic [CNT_W-1:0]         cnt_nxt;
  logic signed [DATA_W-1:0] data_p1;
  logic                     sat_p1;
  logic [CNT_W-1:0]         cnt_p1;

  function automatic logic signed [ACC_W-1:0] sext(input logic [DATA_W-1:0] x);
    return $signed({{ACC_GUARD{x[DATA_W-1]}}, x});
  endfunction

  // True when the accumulator does not fit in 32 signed bits.
  function automatic logic sat_flag(input logic signed [ACC_W-1:0] a);
    logic [ACC_W-DATA_W:0] top;
    top = a[ACC_W-1:DATA_W-1];
    return !((top == '0) || (top == '1));
  endfunction

  function automatic logic signed [DATA_W-1:0] sat32(input logic signed [ACC_W-1:0] a);
    if (!sat_flag(a))
      return $signed(a[DATA_W-1:0]);
    else if (a[ACC_W-1])
      return $signed({1'b1, {(DATA_W-1){1'b0}}});
    else
      return $signed({1'b0, {(DATA_W-1){1'b1}}});
  endfunction

  function automatic logic signed [DATA_W-1:0] relu(input logic signed [DATA_W-1:0] v);
`ifdef NEURON_ACC_RELU_EN
    return v[DATA_W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 16'd1;
  endfunction

  // Ready whenever not holding a result; forced low while reset is asserted.
  assign rdy    = !reset && (state != HOLD);
  assign accept = bus.in_valid && rdy;

  // First beat starts from the bias, later beats add onto the running sum.
  always_comb begin
    acc_sum = '0;
    cnt_nxt = '0;
    if (state == IDLE) begin
      acc_sum = sext(bus.in_bias) + sext(bus.in_product);
      cnt_nxt = 16'd1;
    end else begin
      acc_sum = acc_p0 + sext(bus.in_product);
      cnt_nxt = cnt_inc(cnt_p0);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.in_last ? HOLD : ACCUM;
      ACCUM:   if (accept && bus.in_last) state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---- stage p0: running accumulator and term count ----
  always_ff @(posedge clk) begin
    if (accept) begin
      acc_p0 <= acc_sum;
      cnt_p0 <= cnt_nxt;
    end
  end

  // ---- stage p1: saturated result captured on the final beat ----
  always_ff @(posedge clk) begin
    if (reset) begin
      data_p1 <= '0;
      sat_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else if (accept && bus.in_last) begin
      data_p1 <= relu(sat32(acc_sum));
      sat_p1  <= sat_flag(acc_sum);
      cnt_p1  <= cnt_nxt;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state == HOLD);
  assign bus.out_data  = data_p1;
  assign bus.out_sat   = sat_p1;
  assign bus.out_count = cnt_p1;

endmodule

// File: tb/tb_neuron_accumulator.sv
// Directed bench for neuron_accumulator: reset state, basic accumulation,
// saturation both ways, negative single beat, backpressure, bubbles and
// reset mid-vector.
module tb_neuron_accumulator;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  neuron_accumulator_if bus();

  neuron_accumulator #(.ACC_GUARD(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total  = 0;
  int passed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [31:0] b, input logic [31:0] p, input logic l);
    bus.in_valid   = 1'b1;
    bus.in_bias    = b;
    bus.in_product = p;
    bus.in_last    = l;
    tick();
    bus.in_valid   = 1'b0;
    bus.in_last    = 1'b0;
  endtask

  task automatic accept_result();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    total++; if (bus.in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", bus.in_ready); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 32'h0) $display("FAIL rst_out_data got %h want 0", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL rst_out_sat got %b want 0", bus.out_sat); else passed++;
    total++; if (bus.out_count !== 16'h0) $display("FAIL rst_out_count got %h want 0", bus.out_count); else passed++;
    reset = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_basic();
    send(32'h0001_0000, 32'h0001_8000, 1'b0);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", bus.out_valid); else passed++;
    send(32'hDEAD_BEEF, 32'h0000_8000, 1'b1);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 32'h0003_0000) $display("FAIL basic_data got %h want 00030000", bus.out_data); else passed++;
    total++; if (bus.out_count !== 16'd2) $display("FAIL basic_count got %0d want 2", bus.out_count); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL basic_sat got %b want 0", bus.out_sat); else passed++;
    total++; if (bus.in_ready !== 1'b0) $display("FAIL basic_hold_ready got %b want 0", bus.in_ready); else passed++;
    accept_result();
    total++; if (bus.out_valid !== 1'b0) $display("FAIL basic_drop_valid got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL basic_idle_ready got %b want 1", bus.in_ready); else passed++;
  endtask

  task automatic test_pos_sat();
    send(32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    send(32'h0000_0000, 32'h7FFF_FFFF, 1'b1);
    total++; if (bus.out_data !== 32'h7FFF_FFFF) $display("FAIL possat_data got %h want 7fffffff", bus.out_data); else passed++;
    total++; if (bus.out_sat !== 1'b1) $display("FAIL possat_sat got %b want 1", bus.out_sat); else passed++;
    total++; if (bus.out_count !== 16'd2) $display("FAIL possat_count got %0d want 2", bus.out_count); else passed++;
    accept_result();
  endtask

  task automatic test_neg_sat();
    logic [31:0] exp_d;
`ifdef NEURON_ACC_RELU_EN
    exp_d = 32'h0000_0000;
`else
    exp_d = 32'h8000_0000;
`endif
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    send(32'h0000_0000, 32'h8000_0000, 1'b1);
    total++; if (bus.out_data !== exp_d) $display("FAIL negsat_data got %h want %h", bus.out_data, exp_d); else passed++;
    total++; if (bus.out_sat !== 1'b1) $display("FAIL negsat_sat got %b want 1", bus.out_sat); else passed++;
    accept_result();
  endtask

  task automatic test_neg_single();
    logic [31:0] exp_d;
`ifdef NEURON_ACC_RELU_EN
    exp_d = 32'h0000_0000;
`else
    exp_d = 32'hFFFF_0000;
`endif
    send(32'h0000_0000, 32'hFFFF_0000, 1'b1);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL negone_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== exp_d) $display("FAIL negone_data got %h want %h", bus.out_data, exp_d); else passed++;
    total++; if (bus.out_count !== 16'd1) $display("FAIL negone_count got %0d want 1", bus.out_count); else passed++;
    total++; if (bus.out_sat !== 1'b0) $display("FAIL negone_sat got %b want 0", bus.out_sat); else passed++;
    accept_result();
  endtask

  task automatic test_backpressure();
    send(32'h0000_0000, 32'h0005_0000, 1'b1);
    bus.in_valid   = 1'b1;
    bus.in_product = 32'h0100_0000;
    bus.in_bias    = 32'h0100_0000;
    bus.in_last    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (bus.out_valid !== 1'b1) $display("FAIL bp_valid cyc %0d got %b want 1", i, bus.out_valid); else passed++;
      total++; if (bus.out_data !== 32'h0005_0000) $display("FAIL bp_data cyc %0d got %h want 00050000", i, bus.out_data); else passed++;
      total++; if (bus.in_ready !== 1'b0) $display("FAIL bp_ready cyc %0d got %b want 0", i, bus.in_ready); else passed++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    accept_result();
    send(32'h0000_0000, 32'h0001_0000, 1'b1);
    total++; if (bus.out_data !== 32'h0001_0000) $display("FAIL bp_next_data got %h want 00010000", bus.out_data); else passed++;
    total++; if (bus.out_count !== 16'd1) $display("FAIL bp_next_count got %0d want 1", bus.out_count); else passed++;
    accept_result();
  endtask

  task automatic test_bubbles();
    send(32'h0000_0000, 32'h0001_0000, 1'b0);
    send(32'h7777_7777, 32'h0001_0000, 1'b0);
    bus.in_product = 32'h0700_0000;
    idle(3);
    send(32'h7777_7777, 32'h0001_0000, 1'b0);
    idle(1);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL bub_early_valid got %b want 0", bus.out_valid); else passed++;
    send(32'h7777_7777, 32'h0001_0000, 1'b1);
    total++; if (bus.out_data !== 32'h0004_0000) $display("FAIL bub_data got %h want 00040000", bus.out_data); else passed++;
    total++; if (bus.out_count !== 16'd4) $display("FAIL bub_count got %0d want 4", bus.out_count); else passed++;
    accept_result();
  endtask

  task automatic test_reset_mid();
    send(32'h0003_0000, 32'h0001_0000, 1'b0);
    send(32'h0000_0000, 32'h0001_0000, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);
    total++; if (bus.out_valid !== 1'b0) $display("FAIL rmid_valid got %b want 0", bus.out_valid); else passed++;
    send(32'h0000_0000, 32'h0002_0000, 1'b1);
    total++; if (bus.out_valid !== 1'b1) $display("FAIL rmid_next_valid got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_data !== 32'h0002_0000) $display("FAIL rmid_data got %h want 00020000", bus.out_data); else passed++;
    total++; if (bus.out_count !== 16'd1) $display("FAIL rmid_count got %0d want 1", bus.out_count); else passed++;
    accept_result();
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_valid   = 1'b0;
    bus.in_product = '0;
    bus.in_bias    = '0;
    bus.in_last    = 1'b0;
    bus.out_ready  = 1'b0;
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_neg_single();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
